// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path and its baud generator.
//   UART_OVS    : oversampling ticks per bit period
//   UART_DBIT   : data bits per frame
//   UART_DVSR_W : width of the baud divisor field
//   rx_state_e  : receiver frame-state encoding
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_OVS    = 16;
    localparam int UART_DBIT   = 8;
    localparam int UART_DVSR_W = 11;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

endpackage

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Free-running oversampling tick generator, shared by receiver and transmitter.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous reset, active low
//   dvsr_i  in  divisor; tick period is dvsr_i+1 clocks
//   tick_o  out one-clock tick pulse
// ---------------------------------------------------------------------------
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DVSR_W = UART_DVSR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DVSR_W-1:0] dvsr_i,
    output logic              tick_o
);

    logic [DVSR_W-1:0] cnt_q;
    logic [DVSR_W-1:0] cnt_d;
    logic              tick_q;

    // Wrapping on ">=" lets a divisor lowered mid-count recover at once
    // instead of running the counter all the way round.
    always_comb begin
        cnt_d = cnt_q + DVSR_W'(1);
        if (cnt_q >= dvsr_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_q == dvsr_i);
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
// 8N1 serial receive engine with 16x oversampling.
// Ports:
//   clk          in  system clock
//   rst_n        in  asynchronous reset, active low
//   dvsr_i       in  baud divisor; tick period = dvsr_i+1 clocks
//   rx_i         in  serial line from pad, asynchronous, idle high
//   rxing_o      out high while a frame is in progress
//   rx_done_o    out one-clock pulse, frame complete and d_rx_o valid
//   d_rx_o       out last received byte, held until the next rx_done_o
//   frame_err_o  out one-clock pulse with rx_done_o when the stop bit was 0
// ---------------------------------------------------------------------------
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DBIT   = UART_DBIT,
    parameter int OVS    = UART_OVS,
    parameter int DVSR_W = UART_DVSR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DVSR_W-1:0] dvsr_i,
    input  logic              rx_i,
    output logic              rxing_o,
    output logic              rx_done_o,
    output logic [DBIT-1:0]   d_rx_o,
    output logic              frame_err_o
);

    localparam int S_W = $clog2(OVS);
    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [S_W-1:0] S_MID  = S_W'(OVS / 2 - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(OVS - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(DBIT - 1);

    logic            tick;
    logic [1:0]      sync_q;
    logic            rx_s;

    rx_state_e       state_q, state_d;
    logic [S_W-1:0]  s_q, s_d;
    logic [N_W-1:0]  n_q, n_d;
    logic [DBIT-1:0] shreg_q, shreg_d;
    logic [DBIT-1:0] d_rx_q, d_rx_d;
    logic            done_d, ferr_d;
    logic            rx_done_q, frame_err_q, rxing_q;

    uart_baud_gen #(
        .DVSR_W (DVSR_W)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .dvsr_i (dvsr_i),
        .tick_o (tick)
    );

    // Two-flop synchronizer, reset to the idle-high line level so reset
    // release never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    assign rx_s = sync_q[1];

    // Frame deframer. IDLE reacts on any clock so the start-bit phase is
    // measured from the actual edge; every other state advances on ticks.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shreg_d = shreg_q;
        d_rx_d  = d_rx_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end

            START: begin
                if (tick) begin
                    if (s_q == S_MID) begin
                        if (rx_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        shreg_d = {rx_s, shreg_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + N_W'(1);
                        end
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end

            STOP: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        d_rx_d  = shreg_q;
                        done_d  = 1'b1;
                        ferr_d  = !rx_s;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + S_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs. rxing follows the next state so that it
    // drops in the same clock as the rx_done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_q         <= '0;
            n_q         <= '0;
            shreg_q     <= '0;
            d_rx_q      <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rxing_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            shreg_q     <= shreg_d;
            d_rx_q      <= d_rx_d;
            rx_done_q   <= done_d;
            frame_err_q <= ferr_d;
            rxing_q     <= (state_d != IDLE);
        end
    end

    assign rxing_o     = rxing_q;
    assign rx_done_o   = rx_done_q;
    assign d_rx_o      = d_rx_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_core
// Drives the serial line with whole frames and compares every received byte
// against a queue of frames the bench itself sent.
// ---------------------------------------------------------------------------
module tb_uart_rx_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] dvsr = 11'd3;
    logic        rx = 1'b1;
    logic        rxing;
    logic        rxDone;
    logic [7:0]  dRx;
    logic        frameErr;

    int compared = 0;
    int mismatched = 0;

    int cyc = 0;
    int doneCount = 0;
    int doneCycQ[$];
    int rxFallCyc = 0;
    int rxingRiseCyc = -1;
    int rxingHighSeen = 0;
    logic prevRxing = 1'b0;
    logic prevDone = 1'b0;

    // Expected frames, {frameErr, data}, in send order.
    logic [8:0] expQ[$];
    logic [8:0] expEntry;
    logic [7:0] expLast = 8'h00;

    always #5 clk = ~clk;

    uart_rx_core dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dvsr_i      (dvsr),
        .rx_i        (rx),
        .rxing_o     (rxing),
        .rx_done_o   (rxDone),
        .d_rx_o      (dRx),
        .frame_err_o (frameErr)
    );

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     tag, observed, expected, cyc);
        end
    endtask

    // Output monitor: samples 1ns after each rising edge and retires
    // expected frames whenever a completion pulse shows up.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rxing && !prevRxing) rxingRiseCyc = cyc;
            if (rxing) rxingHighSeen++;
            if (rxDone) begin
                doneCount++;
                doneCycQ.push_back(cyc);
                checkOutput("done_pulse_width", {31'd0, prevDone}, 32'd0);
                checkOutput("rxing_falls_with_done", {31'd0, rxing}, 32'd0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    expEntry = expQ.pop_front();
                    checkOutput("d_rx", {24'd0, dRx}, {24'd0, expEntry[7:0]});
                    checkOutput("frame_err", {31'd0, frameErr}, {31'd0, expEntry[8]});
                    expLast = expEntry[7:0];
                end
            end else if (frameErr) begin
                checkOutput("frame_err_without_done", 32'd1, 32'd0);
            end
            prevRxing = rxing;
            prevDone = rxDone;
        end
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int bitClk();
        return 16 * (int'(dvsr) + 1);
    endfunction

    task automatic holdLine(input logic level, input int clocks);
        rx = level;
        repeat (clocks) @(negedge clk);
    endtask

    // Sends one frame LSB first. A bad stop bit is held low just past its
    // mid-bit sample and then released, so the line returning high is seen
    // as a rejected glitch rather than a new start bit.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                 input int gapBits);
        expQ.push_back({~stopBit, data});
        rxFallCyc = cyc;
        holdLine(1'b0, bitClk());
        for (int i = 0; i < 8; i++) holdLine(data[i], bitClk());
        if (stopBit) begin
            holdLine(1'b1, bitClk());
        end else begin
            holdLine(1'b0, bitClk() * 12 / 16);
            holdLine(1'b1, bitClk() * 4 / 16);
        end
        for (int i = 0; i < gapBits; i++) holdLine(1'b1, bitClk());
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 5000 && expQ.size() != 0; i++) @(negedge clk);
        checkOutput("drain", expQ.size(), 32'd0);
        expQ.delete();
    endtask

    int d0;
    int h0;
    int tA;
    int tB;
    logic [7:0] rndData;
    logic rndStop;
    int rndGap;

    initial begin
        @(negedge clk);
        #1;
        checkOutput("reset_rxing", {31'd0, rxing}, 32'd0);
        checkOutput("reset_done", {31'd0, rxDone}, 32'd0);
        checkOutput("reset_d_rx", {24'd0, dRx}, 32'd0);
        checkOutput("reset_frame_err", {31'd0, frameErr}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Test 1: single clean frame at divisor 3.
        $display("[TB] test 1: 0xA5 at dvsr=3");
        dvsr = 11'd3;
        d0 = doneCount;
        applyStimulus(8'hA5, 1'b1, 2);
        waitDrain();
        checkOutput("t1_done_count", doneCount - d0, 32'd1);
        checkOutput("t1_rxing_rise_latency", rxingRiseCyc - rxFallCyc, 32'd3);
        checkOutput("t1_rxing_idle", {31'd0, rxing}, 32'd0);

        // Test 2: back-to-back frames at divisor 0.
        $display("[TB] test 2: 0x00,0xFF back-to-back at dvsr=0");
        dvsr = 11'd0;
        repeat (40) @(negedge clk);
        d0 = doneCount;
        applyStimulus(8'h00, 1'b1, 0);
        applyStimulus(8'hFF, 1'b1, 2);
        waitDrain();
        checkOutput("t2_done_count", doneCount - d0, 32'd2);
        if (doneCycQ.size() >= 2)
            checkOutput("t2_done_spacing",
                        doneCycQ[doneCycQ.size()-1] - doneCycQ[doneCycQ.size()-2],
                        32'd160);

        // Test 3: short glitch is rejected.
        $display("[TB] test 3: 20-clk glitch at dvsr=3");
        dvsr = 11'd3;
        repeat (200) @(negedge clk);
        d0 = doneCount;
        h0 = rxingHighSeen;
        holdLine(1'b0, 20);
        holdLine(1'b1, 200);
        checkOutput("t3_rxing_pulsed", {31'd0, rxingHighSeen > h0}, 32'd1);
        checkOutput("t3_rxing_back_low", {31'd0, rxing}, 32'd0);
        checkOutput("t3_no_done", doneCount - d0, 32'd0);
        checkOutput("t3_d_rx_held", {24'd0, dRx}, {24'd0, expLast});

        // Test 4: bad stop bit.
        $display("[TB] test 4: 0x3C with stop=0");
        d0 = doneCount;
        applyStimulus(8'h3C, 1'b0, 2);
        waitDrain();
        checkOutput("t4_done_count", doneCount - d0, 32'd1);

        // Break: line low for 10.5 bits gives a zero byte with frame error,
        // then a frame of all ones started by the still-low line.
        $display("[TB] break condition at dvsr=3");
        d0 = doneCount;
        expQ.push_back({1'b1, 8'h00});
        expQ.push_back({1'b0, 8'hFF});
        holdLine(1'b0, bitClk() * 21 / 2);
        holdLine(1'b1, bitClk() * 12);
        waitDrain();
        checkOutput("break_done_count", doneCount - d0, 32'd2);

        // Test 5: reset in the middle of data bit 4.
        $display("[TB] test 5: reset mid-frame");
        expQ.push_back(9'h05A);
        holdLine(1'b0, bitClk());
        for (int i = 0; i < 4; i++) holdLine(tA[0] ^ tA[0] ^ (8'h5A >> i) & 8'h01, bitClk());
        holdLine(1'b1, bitClk() / 2);
        d0 = doneCount;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rxing_in_reset", {31'd0, rxing}, 32'd0);
        checkOutput("t5_d_rx_in_reset", {24'd0, dRx}, 32'd0);
        checkOutput("t5_done_in_reset", {31'd0, rxDone}, 32'd0);
        expQ.delete();
        expLast = 8'h00;
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * bitClk()) @(negedge clk);
        checkOutput("t5_no_done_after_abort", doneCount - d0, 32'd0);
        applyStimulus(8'h81, 1'b1, 2);
        waitDrain();
        checkOutput("t5_done_count", doneCount - d0, 32'd1);

        // Test 6: divisor change while idle.
        $display("[TB] test 6: dvsr 3->7");
        dvsr = 11'd7;
        repeat (2 * bitClk()) @(negedge clk);
        tA = -1;
        tB = -1;
        for (int i = 0; i < 40 && tA < 0; i++) begin
            @(negedge clk);
            if (dut.u_baud.tick_o) tA = cyc;
        end
        for (int i = 0; i < 40 && tB < 0; i++) begin
            @(negedge clk);
            if (dut.u_baud.tick_o) tB = cyc;
        end
        checkOutput("t6_tick_found", {31'd0, (tA >= 0) && (tB >= 0)}, 32'd1);
        checkOutput("t6_tick_period", tB - tA, 32'd8);
        d0 = doneCount;
        applyStimulus(8'hC3, 1'b1, 2);
        waitDrain();
        checkOutput("t6_done_count", doneCount - d0, 32'd1);

        // Randomized frames over several divisors.
        $display("[TB] randomized frames");
        for (int f = 0; f < 16; f++) begin
            if (f % 4 == 0) begin
                waitDrain();
                dvsr = 11'($urandom_range(0, 3));
                repeat (2 * bitClk()) @(negedge clk);
            end
            rndData = 8'($urandom);
            rndStop = ($urandom_range(0, 4) != 0);
            rndGap = rndStop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            applyStimulus(rndData, rndStop, rndGap);
        end
        holdLine(1'b1, 2 * bitClk());
        waitDrain();
        checkOutput("final_rxing_idle", {31'd0, rxing}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
